// File: rtl/sin_cos_requester.sv
// Initiator for the sin/cos lookup unit of the Box-Muller generator: restarts the
// unit per phase word, waits (with timeout) for done, then scales sin/cos by the radius.
module sin_cos_requester #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_phase,
  input  logic [15:0] in_radius,
  output logic        sc_reset,
  output logic        sc_enable,
  output logic [31:0] sc_address,
  input  logic        sc_done,
  input  logic [15:0] sc_sin,
  input  logic [15:0] sc_cos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x0,
  output logic [15:0] out_x1,
  output logic        busy,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and out_x0/out_x1 hold while out_valid is high.

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    MUL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              arm_reg, arm_n;
  logic [31:0]       addr_r, addr_n;
  logic [15:0]       radius_r, radius_n;
  logic [15:0]       sin_r, sin_n;
  logic [15:0]       cos_r, cos_n;
  logic [15:0]       x0_r, x0_n;
  logic [15:0]       x1_r, x1_n;
  logic              out_valid_r, out_valid_n;
  logic              timeout_r, timeout_n;

  logic [31:0]       p0, p1;
  logic [15:0]       s0, s1;
  logic              unused_low_bits;

  // Q3.13 x Q1.15 = Q4.28; keep Q3.13 and saturate if either top bit is set.
  assign p0 = 32'(radius_r) * 32'(sin_r);
  assign p1 = 32'(radius_r) * 32'(cos_r);
  assign s0 = (|p0[31:30]) ? 16'hFFFF : p0[30:15];
  assign s1 = (|p1[31:30]) ? 16'hFFFF : p1[30:15];
  assign unused_low_bits = ^{p0[14:0], p1[14:0]};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    arm_n       = arm_reg;
    addr_n      = addr_r;
    radius_n    = radius_r;
    sin_n       = sin_r;
    cos_n       = cos_r;
    x0_n        = x0_r;
    x1_n        = x1_r;
    out_valid_n = out_valid_r;
    timeout_n   = timeout_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          addr_n   = {in_phase[15:6], 6'b0, in_phase};
          radius_n = in_radius;
          arm_n    = 1'b1;
          cnt_n    = RST_LOAD;
          state_n  = ARM;
        end
      end
      ARM: begin
        if (cnt == '0) begin
          arm_n   = 1'b0;
          cnt_n   = TO_LOAD;
          state_n = WAIT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WAIT: begin
        if (sc_done) begin
          sin_n   = sc_sin;
          cos_n   = sc_cos;
          state_n = MUL;
        end else if (cnt == '0) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      MUL: begin
        x0_n        = s0;
        x1_n        = s1;
        out_valid_n = 1'b1;
        state_n     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      arm_reg     <= 1'b0;
      addr_r      <= '0;
      radius_r    <= '0;
      sin_r       <= '0;
      cos_r       <= '0;
      x0_r        <= '0;
      x1_r        <= '0;
      out_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      arm_reg     <= arm_n;
      addr_r      <= addr_n;
      radius_r    <= radius_n;
      sin_r       <= sin_n;
      cos_r       <= cos_n;
      x0_r        <= x0_n;
      x1_r        <= x1_n;
      out_valid_r <= out_valid_n;
      timeout_r   <= timeout_n;
    end
  end

  // The unit restarts whenever this block is reset, not only when armed.
  assign sc_reset    = reset | arm_reg;
  assign sc_enable   = (state == WAIT);
  assign sc_address  = addr_r;
  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = out_valid_r;
  assign out_x0      = x0_r;
  assign out_x1      = x1_r;
  assign timeout_err = timeout_r;
  assign state_dbg   = state;

endmodule

// File: tb/tb_sin_cos_requester.sv
// Directed bench for sin_cos_requester with a small behavioural sin/cos unit
// that raises a sticky done four edges after its restart is released.
module tb_sin_cos_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_phase = '0;
  logic [15:0] in_radius = '0;
  logic        sc_reset;
  logic        sc_enable;
  logic [31:0] sc_address;
  logic        sc_done = 1'b0;
  logic [15:0] sc_sin = '0;
  logic [15:0] sc_cos = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_x0;
  logic [15:0] out_x1;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  bit model_silent = 1'b0;
  int model_cnt = 0;

  sin_cos_requester #(.RST_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_phase(in_phase), .in_radius(in_radius), .sc_reset(sc_reset),
    .sc_enable(sc_enable), .sc_address(sc_address), .sc_done(sc_done),
    .sc_sin(sc_sin), .sc_cos(sc_cos), .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_x1(out_x1), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Behavioural sin/cos unit
  always @(posedge clk) begin
    if (sc_reset) begin
      model_cnt <= 0;
      sc_done   <= 1'b0;
    end else if (!model_silent && !sc_done) begin
      if (model_cnt == 3) sc_done <= 1'b1;
      model_cnt <= model_cnt + 1;
    end
  end

  // Driver tasks
  task automatic accept(input logic [15:0] ph, input logic [15:0] rad);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b expected 1", in_ready);
    end
    in_valid  = 1'b1;
    in_phase  = ph;
    in_radius = rad;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int limit, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sc_reset !== 1'b1) begin errors++; $display("FAIL rst_sc_reset_high: got %b expected 1", sc_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_in_reset: got %b expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_x0 !== 16'h0) begin errors++; $display("FAIL rst_out_x0: got %h expected 0000", out_x0); end
    checks++; if (out_x1 !== 16'h0) begin errors++; $display("FAIL rst_out_x1: got %h expected 0000", out_x1); end
    checks++; if (sc_address !== 32'h0) begin errors++; $display("FAIL rst_sc_address: got %h expected 00000000", sc_address); end
    checks++; if (sc_enable !== 1'b0) begin errors++; $display("FAIL rst_sc_enable: got %b expected 0", sc_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (sc_reset !== 1'b0) begin errors++; $display("FAIL rst_sc_reset_low: got %b expected 0", sc_reset); end
  endtask

  task automatic test_basic();
    int lat;
    sc_sin = 16'h4000;
    sc_cos = 16'h7000;
    accept(16'h0040, 16'h2000);
    checks++; if (sc_address !== 32'h0040_0040) begin errors++; $display("FAIL basic_addr_early: got %h expected 00400040", sc_address); end
    checks++; if (sc_reset !== 1'b1) begin errors++; $display("FAIL basic_arm_c0: got %b expected 1", sc_reset); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (sc_reset !== 1'b1) begin errors++; $display("FAIL basic_arm_c1: got %b expected 1", sc_reset); end
    @(negedge clk);
    checks++; if (sc_reset !== 1'b0) begin errors++; $display("FAIL basic_arm_c2: got %b expected 0", sc_reset); end
    checks++; if (sc_enable !== 1'b1) begin errors++; $display("FAIL basic_enable: got %b expected 1", sc_enable); end
    wait_out(40, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6 cycles after wait entry", lat); end
    checks++; if (out_x0 !== 16'h1000) begin errors++; $display("FAIL basic_x0: got %h expected 1000", out_x0); end
    checks++; if (out_x1 !== 16'h1C00) begin errors++; $display("FAIL basic_x1: got %h expected 1c00", out_x1); end
    checks++; if (sc_address !== 32'h0040_0040) begin errors++; $display("FAIL basic_addr_late: got %h expected 00400040", sc_address); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_cleared: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_saturation();
    int lat;
    sc_sin = 16'hFFFF;
    sc_cos = 16'h1000;
    accept(16'hFFFF, 16'hFFFF);
    wait_out(40, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL sat_a_latency: got %0d expected 8", lat); end
    checks++; if (out_x0 !== 16'hFFFF) begin errors++; $display("FAIL sat_a_x0: got %h expected ffff", out_x0); end
    checks++; if (out_x1 !== 16'h1FFF) begin errors++; $display("FAIL sat_a_x1: got %h expected 1fff", out_x1); end
    release_out();
    sc_sin = 16'h8000;
    sc_cos = 16'h7FFF;
    accept(16'h0000, 16'h8000);
    wait_out(40, lat);
    checks++; if (out_x0 !== 16'hFFFF) begin errors++; $display("FAIL sat_b_bit30_x0: got %h expected ffff", out_x0); end
    checks++; if (out_x1 !== 16'h7FFF) begin errors++; $display("FAIL sat_b_x1: got %h expected 7fff", out_x1); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    sc_sin = 16'h2000;
    sc_cos = 16'h0000;
    accept(16'h0080, 16'h2000);
    wait_out(40, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
    in_valid = 1'b1;
    in_phase = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_x0 !== 16'h0800 || out_x1 !== 16'h0000) begin errors++; $display("FAIL bp_data_hold[%0d]: got %h/%h expected 0800/0000", i, out_x0, out_x1); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    checks++; if (sc_address !== 32'h0080_0080) begin errors++; $display("FAIL bp_addr_stable: got %h expected 00800080", sc_address); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %b expected 1", busy); end
    checks++; if (sc_address !== 32'h1200_1234) begin errors++; $display("FAIL bp_next_addr: got %h expected 12001234", sc_address); end
    wait_out(40, lat);
    release_out();
  endtask

  task automatic test_timeout();
    int lat;
    bit seen;
    model_silent = 1'b1;
    accept(16'h0100, 16'h2000);
    lat = 0;
    seen = 1'b0;
    while (timeout_err !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (lat !== 18) begin errors++; $display("FAIL to_latency: got %0d expected 18 cycles after accept", lat); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_no_output: got %b expected 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL to_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
    model_silent = 1'b0;
    sc_sin = 16'h1000;
    sc_cos = 16'h0800;
    accept(16'h0200, 16'h4000);
    wait_out(40, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL to_after_latency: got %0d expected 8", lat); end
    checks++; if (out_x0 !== 16'h0800 || out_x1 !== 16'h0400) begin errors++; $display("FAIL to_after_data: got %h/%h expected 0800/0400", out_x0, out_x1); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    release_out();
  endtask

  task automatic test_reset_in_wait();
    int lat;
    sc_sin = 16'h7FFF;
    sc_cos = 16'h0001;
    accept(16'h0300, 16'h2000);
    repeat (4) @(negedge clk);
    checks++; if (sc_enable !== 1'b1) begin errors++; $display("FAIL rw_in_wait: got %b expected 1", sc_enable); end
    reset = 1'b1;
    #1;
    checks++; if (sc_reset !== 1'b1) begin errors++; $display("FAIL rw_sc_reset: got %b expected 1", sc_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_out_valid: got %b expected 0", out_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rw_timeout_err: got %b expected 0", timeout_err); end
    @(negedge clk);
    reset = 1'b0;
    accept(16'h0300, 16'h2000);
    wait_out(40, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL rw_after_latency: got %0d expected 8", lat); end
    checks++; if (out_x0 !== 16'h1FFF || out_x1 !== 16'h0000) begin errors++; $display("FAIL rw_after_data: got %h/%h expected 1fff/0000", out_x0, out_x1); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
